wb_regfile: RTL and testbench

//   Write-back stage and architectural register file of the 5-stage MIPS pipeline. Consumes the
//   MEM/WB pipeline register outputs, selects the destination register and write-back data, and

---
 rtl/wb_regfile_if.sv | 38 +++
 rtl/wb_regfile.sv | 88 ++++++++
 tb/tb_wb_regfile.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : wb_regfile_if
// Purpose  : MEM/WB write-back inputs, ID-stage read ports and the write-back
//            bus of the MIPS register file, bundled as one interface.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface wb_regfile_if;
  logic [1:0]  RegDst_in;
  logic        RegWr_in;
  logic [1:0]  MemToReg_in;
  logic [31:0] PC_plus_4_in;
  logic [31:0] ALU_in;
  logic [31:0] mem_data_in;
  logic [4:0]  Rt_in;
  logic [4:0]  Rd_in;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] wb_count;

  modport master (
    output RegDst_in, RegWr_in, MemToReg_in, PC_plus_4_in, ALU_in, mem_data_in,
           Rt_in, Rd_in, rs_addr, rt_addr,
    input  rs_data, rt_data, wb_en, wb_addr, wb_data, wb_count
  );

  modport slave (
    input  RegDst_in, RegWr_in, MemToReg_in, PC_plus_4_in, ALU_in, mem_data_in,
           Rt_in, Rd_in, rs_addr, rt_addr,
    output rs_data, rt_data, wb_en, wb_addr, wb_data, wb_count
  );
endinterface
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : wb_regfile
// Purpose  : MIPS write-back stage and 32x32 register file with two
//            combinational read ports and optional write-through bypass.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module wb_regfile #(
  parameter logic [31:0] SP_INIT = 32'h0000_0400,
  parameter int          XP_IDX  = 26,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  wb_regfile_if.slave   bus
);

  localparam logic [4:0] c_XP_ADDR = 5'(XP_IDX);
  localparam logic [4:0] c_RA_ADDR = 5'd31;
  localparam int         c_SP_IDX  = 29;

  // Entry 0 is reset to zero and never written (wb_en excludes address 0).
  logic [31:0] r_regs [32];
  logic [31:0] r_wb_count;

  logic [4:0]  w_wb_addr;
  logic [31:0] w_wb_data;
  logic        w_wb_en;

  always_comb begin
    w_wb_addr = bus.Rd_in;
    unique case (bus.RegDst_in)
      2'b00:   w_wb_addr = bus.Rd_in;
      2'b01:   w_wb_addr = bus.Rt_in;
      2'b10:   w_wb_addr = c_RA_ADDR;
      default: w_wb_addr = c_XP_ADDR;
    endcase
  end

  always_comb begin
    w_wb_data = bus.ALU_in;
    unique case (bus.MemToReg_in)
      2'b01:   w_wb_data = bus.mem_data_in;
      2'b10:   w_wb_data = bus.PC_plus_4_in;
      default: w_wb_data = bus.ALU_in;
    endcase
  end

  assign w_wb_en = bus.RegWr_in && (w_wb_addr != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= (i == c_SP_IDX) ? SP_INIT : 32'h0;
      end
      r_wb_count <= 32'h0;
    end else if (w_wb_en) begin
      r_regs[w_wb_addr] <= w_wb_data;
      r_wb_count        <= r_wb_count + 32'd1;
    end
  end

  // r0 reads as zero even when a (discarded) write targets it.
  always_comb begin
    bus.rs_data = r_regs[bus.rs_addr];
    if (bus.rs_addr == 5'd0) begin
      bus.rs_data = 32'h0;
    end else if (BYPASS && w_wb_en && (bus.rs_addr == w_wb_addr)) begin
      bus.rs_data = w_wb_data;
    end
  end

  always_comb begin
    bus.rt_data = r_regs[bus.rt_addr];
    if (bus.rt_addr == 5'd0) begin
      bus.rt_data = 32'h0;
    end else if (BYPASS && w_wb_en && (bus.rt_addr == w_wb_addr)) begin
      bus.rt_data = w_wb_data;
    end
  end

  assign bus.wb_en    = w_wb_en;
  assign bus.wb_addr  = w_wb_addr;
  assign bus.wb_data  = w_wb_data;
  assign bus.wb_count = r_wb_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_wb_regfile
// Purpose  : Self-checking bench for wb_regfile (bypass and non-bypass builds).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_regfile;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_regfile_if bus ();
  wb_regfile_if bus_nb ();

  wb_regfile #(.SP_INIT(32'h0000_0400), .XP_IDX(26), .BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  wb_regfile #(.SP_INIT(32'h0000_0400), .XP_IDX(26), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .bus(bus_nb)
  );

  typedef struct {
    logic [1:0]  dst;
    logic        wr;
    logic [1:0]  m2r;
    logic [31:0] pc4, alu, mem;
    logic [4:0]  rt, rd, ra, rb;
    logic        en;
    logic [4:0]  waddr;
    logic [31:0] wdata, rsd, rtd, cnt;
  } vec_t;

  typedef struct {
    logic        en;
    logic [4:0]  waddr;
    logic [31:0] wdata, rsd, rtd, cnt;
  } exp_t;

  vec_t vecs [14];
  exp_t sb_q [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(
    input logic [1:0] dst, input logic wr, input logic [1:0] m2r,
    input logic [31:0] pc4, input logic [31:0] alu, input logic [31:0] mem,
    input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] ra, input logic [4:0] rb,
    input logic en, input logic [4:0] waddr, input logic [31:0] wdata,
    input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] cnt);
    vec_t v;
    v.dst = dst; v.wr = wr; v.m2r = m2r; v.pc4 = pc4; v.alu = alu; v.mem = mem;
    v.rt = rt; v.rd = rd; v.ra = ra; v.rb = rb;
    v.en = en; v.waddr = waddr; v.wdata = wdata; v.rsd = rsd; v.rtd = rtd; v.cnt = cnt;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.RegDst_in    = v.dst;
    bus.RegWr_in     = v.wr;
    bus.MemToReg_in  = v.m2r;
    bus.PC_plus_4_in = v.pc4;
    bus.ALU_in       = v.alu;
    bus.mem_data_in  = v.mem;
    bus.Rt_in        = v.rt;
    bus.Rd_in        = v.rd;
    bus.rs_addr      = v.ra;
    bus.rt_addr      = v.rb;
  endtask

  task automatic idle_nb();
    bus_nb.RegDst_in    = 2'b00;
    bus_nb.RegWr_in     = 1'b0;
    bus_nb.MemToReg_in  = 2'b00;
    bus_nb.PC_plus_4_in = 32'h0;
    bus_nb.ALU_in       = 32'h0;
    bus_nb.mem_data_in  = 32'h0;
    bus_nb.Rt_in        = 5'd0;
    bus_nb.Rd_in        = 5'd0;
    bus_nb.rs_addr      = 5'd0;
    bus_nb.rt_addr      = 5'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    vec_t nop;
    //         dst   wr  m2r   pc4           alu           mem          rt  rd  ra  rb   en waddr wdata         rsd           rtd           cnt
    vecs[0]  = mkv(2'b00,0,2'b00,32'h0,        32'h11,       32'h0,       0,  7,  29, 0,   0, 7,  32'h11,       32'h400,      32'h0,        0);
    vecs[1]  = mkv(2'b00,1,2'b00,32'h0,        32'hDEAD_BEEF,32'h0,       0,  5,  5,  29,  1, 5,  32'hDEAD_BEEF,32'hDEAD_BEEF,32'h400,      0);
    vecs[2]  = mkv(2'b00,0,2'b00,32'h0,        32'h0,        32'h0,       0,  5,  5,  5,   0, 5,  32'h0,        32'hDEAD_BEEF,32'hDEAD_BEEF,1);
    vecs[3]  = mkv(2'b10,1,2'b10,32'h0040_0008,32'h99,       32'h0,       0,  0,  31, 31,  1, 31, 32'h0040_0008,32'h0040_0008,32'h0040_0008,1);
    vecs[4]  = mkv(2'b11,1,2'b00,32'h0,        32'hCAFE_0001,32'h0,       0,  0,  26, 31,  1, 26, 32'hCAFE_0001,32'hCAFE_0001,32'h0040_0008,2);
    vecs[5]  = mkv(2'b01,1,2'b01,32'h0,        32'h0,        32'h1234,    0,  9,  0,  26,  0, 0,  32'h1234,     32'h0,        32'hCAFE_0001,3);
    vecs[6]  = mkv(2'b01,1,2'b01,32'h0,        32'h0,        32'h1234,    8,  0,  8,  0,   1, 8,  32'h1234,     32'h1234,     32'h0,        3);
    vecs[7]  = mkv(2'b00,1,2'b11,32'h4,        32'hA5A5_0000,32'hFFFF,    0,  12, 12, 8,   1, 12, 32'hA5A5_0000,32'hA5A5_0000,32'h1234,     4);
    vecs[8]  = mkv(2'b00,0,2'b00,32'h0,        32'h0,        32'h0,       0,  1,  31, 26,  0, 1,  32'h0,        32'h0040_0008,32'hCAFE_0001,5);
    vecs[9]  = mkv(2'b00,0,2'b00,32'h0,        32'h0,        32'h0,       0,  1,  12, 5,   0, 1,  32'h0,        32'hA5A5_0000,32'hDEAD_BEEF,5);
    vecs[10] = mkv(2'b00,1,2'b10,32'h100,      32'h0,        32'h0,       0,  5,  5,  5,   1, 5,  32'h100,      32'h100,      32'h100,      5);
    vecs[11] = mkv(2'b00,0,2'b00,32'h0,        32'h0,        32'h0,       0,  5,  5,  8,   0, 5,  32'h0,        32'h100,      32'h1234,     6);
    vecs[12] = mkv(2'b01,1,2'b00,32'h0,        32'h800,      32'h0,       29, 0,  29, 30,  1, 29, 32'h800,      32'h800,      32'h0,        6);
    vecs[13] = mkv(2'b00,0,2'b00,32'h0,        32'h0,        32'h0,       0,  0,  29, 29,  0, 0,  32'h0,        32'h800,      32'h800,      7);
    nop = mkv(2'b00,0,2'b00,32'h0,32'h0,32'h0,0,0,0,0, 0,0,32'h0,32'h0,32'h0,0);

    // Reset, then read every register through both ports.
    reset = 1'b1;
    drive(nop);
    idle_nb();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.rs_addr = 5'(i);
      bus.rt_addr = 5'(31 - i);
      #1;
      chk($sformatf("reset_rs_r%0d", i), bus.rs_data, (i == 29) ? 32'h400 : 32'h0);
      chk($sformatf("reset_rt_r%0d", 31 - i), bus.rt_data, ((31 - i) == 29) ? 32'h400 : 32'h0);
    end
    chk("reset_wb_count", bus.wb_count, 32'h0);
    chk("reset_nb_count", bus_nb.wb_count, 32'h0);

    // Table vectors: expectation queued at drive, popped at sample.
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      drive(vecs[k]);
      e.en = vecs[k].en; e.waddr = vecs[k].waddr; e.wdata = vecs[k].wdata;
      e.rsd = vecs[k].rsd; e.rtd = vecs[k].rtd; e.cnt = vecs[k].cnt;
      sb_q.push_back(e);
      #2;
      if (sb_q.size() == 0) begin
        chk($sformatf("v%0d_scoreboard_empty", k), 32'h1, 32'h0);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("v%0d_wb_en", k),    {31'h0, bus.wb_en}, {31'h0, e.en});
        chk($sformatf("v%0d_wb_addr", k),  {27'h0, bus.wb_addr}, {27'h0, e.waddr});
        chk($sformatf("v%0d_wb_data", k),  bus.wb_data, e.wdata);
        chk($sformatf("v%0d_rs_data", k),  bus.rs_data, e.rsd);
        chk($sformatf("v%0d_rt_data", k),  bus.rt_data, e.rtd);
        chk($sformatf("v%0d_wb_count", k), bus.wb_count, e.cnt);
      end
    end

    // Counter wrap: backdoor preload to all-ones, then one committed write.
    @(negedge clk);
    drive(nop);
    dut.r_wb_count = 32'hFFFF_FFFF;
    #1;
    chk("wrap_preload", bus.wb_count, 32'hFFFF_FFFF);
    @(negedge clk);
    drive(mkv(2'b00,1,2'b00,32'h0,32'h1,32'h0,0,10,0,0, 0,0,32'h0,32'h0,32'h0,0));
    @(negedge clk);
    drive(nop);
    bus.rs_addr = 5'd10;
    #1;
    chk("wrap_count_zero", bus.wb_count, 32'h0);
    chk("wrap_r10", bus.rs_data, 32'h1);

    // Reset wins over a simultaneous write; outputs stay combinational.
    @(negedge clk);
    reset = 1'b1;
    drive(mkv(2'b00,1,2'b00,32'h0,32'h7,32'h0,0,3,3,0, 0,0,32'h0,32'h0,32'h0,0));
    #2;
    chk("rst_wb_en_comb", {31'h0, bus.wb_en}, 32'h1);
    chk("rst_wb_addr_comb", {27'h0, bus.wb_addr}, 32'd3);
    chk("rst_wb_data_comb", bus.wb_data, 32'h7);
    @(negedge clk);
    reset = 1'b0;
    drive(nop);
    bus.rs_addr = 5'd3;
    bus.rt_addr = 5'd5;
    #1;
    chk("rst_r3_dropped", bus.rs_data, 32'h0);
    chk("rst_r5_cleared", bus.rt_data, 32'h0);
    chk("rst_count_zero", bus.wb_count, 32'h0);
    bus.rs_addr = 5'd29;
    bus.rt_addr = 5'd31;
    #1;
    chk("rst_sp_init", bus.rs_data, 32'h400);
    chk("rst_r31_cleared", bus.rt_data, 32'h0);

    // Non-bypass build: same-cycle read returns the old value.
    @(negedge clk);
    bus_nb.RegWr_in = 1'b1;
    bus_nb.Rd_in    = 5'd3;
    bus_nb.ALU_in   = 32'h7;
    bus_nb.rs_addr  = 5'd3;
    bus_nb.rt_addr  = 5'd3;
    #2;
    chk("nb_wb_en", {31'h0, bus_nb.wb_en}, 32'h1);
    chk("nb_rs_old", bus_nb.rs_data, 32'h0);
    chk("nb_rt_old", bus_nb.rt_data, 32'h0);
    @(negedge clk);
    idle_nb();
    bus_nb.rs_addr = 5'd3;
    #1;
    chk("nb_rs_new", bus_nb.rs_data, 32'h7);
    chk("nb_count", bus_nb.wb_count, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
